// File: rtl/ppu_oam_animator_if.sv
// Bus bundle between the OAM animator and its surroundings: NMI/control inputs,
// trajectory-table port and the CPU-side PPU register write bus.
interface ppu_oam_animator_if;
    logic       nmi;
    logic       enable;
    logic       scroll_en;
    logic [7:0] scroll_y;
    logic [7:0] step;
    logic [7:0] tbl_idx;
    logic [7:0] tbl_x;
    logic [7:0] tbl_y;
    logic [2:0] address;
    logic [7:0] ppu_data;
    logic       ppu_rw;
    logic       ppu_cs;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    modport slave (
        input  nmi, enable, scroll_en, scroll_y, step, tbl_x, tbl_y,
        output tbl_idx, address, ppu_data, ppu_rw, ppu_cs, busy, frame_done, overrun
    );

    modport master (
        output nmi, enable, scroll_en, scroll_y, step, tbl_x, tbl_y,
        input  tbl_idx, address, ppu_data, ppu_rw, ppu_cs, busy, frame_done, overrun
    );
endinterface

// File: rtl/ppu_oam_animator.sv
// On each accepted NMI edge, writes the scroll registers and the Y/X bytes of
// NUM_SPR OAM entries taken from a phase-shifted trajectory table.
module ppu_oam_animator #(
    parameter int unsigned NUM_SPR   = 4,
    parameter int unsigned TBL_DEPTH = 200,
    parameter int unsigned PHASE     = 25,
    parameter int unsigned WAIT_CYC  = 1
) (
    input logic              clk,
    input logic              rst_n,
    ppu_oam_animator_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, SCR_X, SCR_Y, OAM_Y_ADDR, FETCH, WR_Y, OAM_X_ADDR, WR_X, WAIT, DONE
    } state_e;

    localparam logic [8:0] DEPTH9    = 9'(TBL_DEPTH);
    localparam logic [8:0] PHASE9    = 9'(PHASE);
    localparam logic [3:0] LAST_SPR  = 4'(NUM_SPR - 1);
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYC - 1);

    state_e     state_q, state_d, ret_q, ret_d;
    logic [2:0] waitCnt_q, waitCnt_d;
    logic [3:0] spr_q, spr_d;
    logic [7:0] base_q, base_d, fineX_q, fineX_d, tblIdx_q, tblIdx_d;
    logic [7:0] sprX_q, sprX_d, sprY_q, sprY_d;
    logic [7:0] scrollY_q, scrollY_d, stepMod_q, stepMod_d;
    logic       scrollEn_q, scrollEn_d, overrun_q, overrun_d;
    logic       prevNmi_q, armed_q;

    logic       nmiRise;
    logic [8:0] stepWide, idxSum, idxNext, baseSum, baseNext;
    logic [2:0] addr;
    logic [7:0] data;
    logic       rw, cs;

    // armed_q blocks a frame until nmi has been seen low at least once after reset
    assign nmiRise = bus.nmi & ~prevNmi_q & armed_q;

    assign stepWide = {1'b0, bus.step} % DEPTH9;
    assign idxSum   = {1'b0, tblIdx_q} + PHASE9;
    assign idxNext  = (idxSum >= DEPTH9) ? idxSum - DEPTH9 : idxSum;
    assign baseSum  = {1'b0, base_q} + {1'b0, stepMod_q};
    assign baseNext = (baseSum >= DEPTH9) ? baseSum - DEPTH9 : baseSum;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        waitCnt_d  = waitCnt_q;
        spr_d      = spr_q;
        base_d     = base_q;
        fineX_d    = fineX_q;
        tblIdx_d   = tblIdx_q;
        sprX_d     = sprX_q;
        sprY_d     = sprY_q;
        scrollEn_d = scrollEn_q;
        scrollY_d  = scrollY_q;
        stepMod_d  = stepMod_q;
        overrun_d  = nmiRise && (state_q != IDLE);
        addr       = 3'd0;
        data       = 8'd0;
        rw         = 1'b0;
        cs         = 1'b1;

        // Every write state strobes for one cycle, then parks in WAIT with ret_q as its successor
        if (state_q inside {SCR_X, SCR_Y, OAM_Y_ADDR, WR_Y, OAM_X_ADDR, WR_X}) begin
            rw        = 1'b1;
            cs        = 1'b0;
            state_d   = WAIT;
            waitCnt_d = WAIT_LAST;
        end

        case (state_q)
            IDLE: begin
                if (nmiRise && bus.enable) begin
                    scrollEn_d = bus.scroll_en;
                    scrollY_d  = bus.scroll_y;
                    stepMod_d  = stepWide[7:0];
                    tblIdx_d   = base_q;
                    spr_d      = 4'd0;
                    state_d    = bus.scroll_en ? SCR_X : FETCH;
                end
            end
            SCR_X: begin
                addr    = 3'd5;
                data    = fineX_q;
                fineX_d = fineX_q + 8'd1;
                ret_d   = SCR_Y;
            end
            SCR_Y: begin
                addr  = 3'd5;
                data  = scrollY_q;
                ret_d = FETCH;
            end
            FETCH: state_d = OAM_Y_ADDR;
            OAM_Y_ADDR: begin
                addr   = 3'd3;
                data   = {2'b00, spr_q, 2'b00};
                sprX_d = bus.tbl_x;
                sprY_d = bus.tbl_y;
                ret_d  = WR_Y;
            end
            WR_Y: begin
                addr  = 3'd4;
                data  = sprY_q;
                ret_d = OAM_X_ADDR;
            end
            OAM_X_ADDR: begin
                addr  = 3'd3;
                data  = {2'b00, spr_q, 2'b11};
                ret_d = WR_X;
            end
            WR_X: begin
                addr = 3'd4;
                data = sprX_q;
                if (spr_q == LAST_SPR) begin
                    ret_d = DONE;
                end else begin
                    ret_d    = FETCH;
                    spr_d    = spr_q + 4'd1;
                    tblIdx_d = idxNext[7:0];
                end
            end
            WAIT: begin
                if (waitCnt_q == 3'd0) state_d = ret_q;
                else waitCnt_d = waitCnt_q - 3'd1;
            end
            DONE: begin
                base_d  = baseNext[7:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ret_q      <= IDLE;
            waitCnt_q  <= 3'd0;
            spr_q      <= 4'd0;
            base_q     <= 8'd0;
            fineX_q    <= 8'd0;
            tblIdx_q   <= 8'd0;
            sprX_q     <= 8'd0;
            sprY_q     <= 8'd0;
            scrollEn_q <= 1'b0;
            scrollY_q  <= 8'd0;
            stepMod_q  <= 8'd0;
            overrun_q  <= 1'b0;
            prevNmi_q  <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            waitCnt_q  <= waitCnt_d;
            spr_q      <= spr_d;
            base_q     <= base_d;
            fineX_q    <= fineX_d;
            tblIdx_q   <= tblIdx_d;
            sprX_q     <= sprX_d;
            sprY_q     <= sprY_d;
            scrollEn_q <= scrollEn_d;
            scrollY_q  <= scrollY_d;
            stepMod_q  <= stepMod_d;
            overrun_q  <= overrun_d;
            prevNmi_q  <= bus.nmi;
            armed_q    <= armed_q | ~bus.nmi;
        end
    end

    assign bus.tbl_idx    = tblIdx_q;
    assign bus.address    = addr;
    assign bus.ppu_data   = data;
    assign bus.ppu_rw     = rw;
    assign bus.ppu_cs     = cs;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = (state_q == DONE);
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_ppu_oam_animator.sv
// Randomized bench for ppu_oam_animator: a frame-level model builds the expected
// PPU write list, frame length and pulse counts for every NMI.
module tb_ppu_oam_animator;

   localparam int NUM_SPR   = 4;
   localparam int TBL_DEPTH = 200;
   localparam int PHASE     = 25;
   localparam int WAIT_CYC  = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   ppu_oam_animator_if bus();

   ppu_oam_animator #(
      .NUM_SPR(NUM_SPR), .TBL_DEPTH(TBL_DEPTH), .PHASE(PHASE), .WAIT_CYC(WAIT_CYC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int mBase  = 0;
   int mFineX = 0;
   logic [10:0] expQ[$];
   logic [10:0] obsQ[$];

   int busyCycles  = 0;
   int doneCount   = 0;
   int ovCount     = 0;
   int sinceStrobe = 100;

   // Trajectory table contents are bijective so a wrong index shows up as wrong data
   function automatic logic [7:0] tblX(input logic [7:0] i);
      return i ^ 8'hA5;
   endfunction

   function automatic logic [7:0] tblY(input logic [7:0] i);
      return i + 8'd37;
   endfunction

   // Table ROM with one cycle of read latency
   always @(posedge clk) begin
      bus.tbl_x <= tblX(bus.tbl_idx);
      bus.tbl_y <= tblY(bus.tbl_idx);
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit en, input bit sEn, input logic [7:0] sy, input logic [7:0] st);
      bus.enable    = en;
      bus.scroll_en = sEn;
      bus.scroll_y  = sy;
      bus.step      = st;
   endtask

   // Frame model: expected writes in order, then advance the base index
   task automatic buildExpected(input bit sEn, input logic [7:0] sy, input logic [7:0] st);
      int idx;
      expQ.delete();
      if (sEn) begin
         expQ.push_back({3'd5, 8'(mFineX)});
         mFineX = (mFineX + 1) % 256;
         expQ.push_back({3'd5, sy});
      end
      for (int k = 0; k < NUM_SPR; k++) begin
         idx = (mBase + k * PHASE) % TBL_DEPTH;
         expQ.push_back({3'd3, 8'(4 * k)});
         expQ.push_back({3'd4, tblY(8'(idx))});
         expQ.push_back({3'd3, 8'(4 * k + 3)});
         expQ.push_back({3'd4, tblX(8'(idx))});
      end
      mBase = (mBase + int'(st)) % TBL_DEPTH;
   endtask

   // Bus monitor: records strobes, checks idle values and strobe spacing
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.busy) busyCycles++;
         if (bus.frame_done) doneCount++;
         if (bus.overrun) ovCount++;
         if (bus.ppu_cs === 1'b0) begin
            obsQ.push_back({bus.address, bus.ppu_data});
            checkOutput("strobe_rw", 32'(bus.ppu_rw), 32'd1);
            checkOutput("strobe_gap", 32'(sinceStrobe >= WAIT_CYC), 32'd1);
            sinceStrobe = 0;
         end else begin
            checkOutput("idle_bus", 32'({bus.ppu_rw, bus.address, bus.ppu_data}), 32'd0);
            sinceStrobe++;
         end
      end
   end

   task automatic runFrame(input bit en, input bit sEn, input logic [7:0] sy,
                           input logic [7:0] st, input bit doOverrun);
      int expLen;
      int n;
      @(negedge clk);
      bus.nmi = 1'b0;
      applyStimulus(en, sEn, sy, st);
      @(negedge clk);
      obsQ.delete();
      busyCycles = 0;
      doneCount  = 0;
      ovCount    = 0;
      if (en) buildExpected(sEn, sy, st);
      else expQ.delete();
      bus.nmi = 1'b1;
      @(negedge clk);
      applyStimulus(en, ~sEn, ~sy, st ^ 8'h5A);
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (doOverrun && c == 10) bus.nmi = 1'b0;
         if (doOverrun && c == 12) bus.nmi = 1'b1;
      end
      checkOutput("frame_ended", 32'(bus.busy), 32'd0);
      checkOutput("write_count", 32'(obsQ.size()), 32'(expQ.size()));
      n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("write[%0d]", i), 32'(obsQ[i]), 32'(expQ[i]));
      expLen = en ? ((sEn ? 2 : 0) + 4 * NUM_SPR) * (1 + WAIT_CYC) + NUM_SPR + 1 : 0;
      checkOutput("frame_len", 32'(busyCycles), 32'(expLen));
      checkOutput("frame_done_count", 32'(doneCount), 32'(en ? 1 : 0));
      checkOutput("overrun_count", 32'(ovCount), 32'(doOverrun ? 1 : 0));
   endtask

   initial begin
      bit found;
      bus.nmi = 1'b1;
      applyStimulus(1'b1, 1'b1, 8'h00, 8'd1);
      repeat (3) @(negedge clk);
      checkOutput("reset_bus", 32'({bus.ppu_cs, bus.ppu_rw, bus.address, bus.ppu_data}), 32'h1000);
      checkOutput("reset_tbl_idx", 32'(bus.tbl_idx), 32'd0);
      checkOutput("reset_flags", 32'({bus.busy, bus.frame_done, bus.overrun}), 32'd0);

      // nmi held high across reset release must not start a frame
      rst_n = 1'b1;
      busyCycles = 0;
      obsQ.delete();
      repeat (6) @(negedge clk);
      checkOutput("nmi_held_no_frame", 32'(busyCycles), 32'd0);
      checkOutput("nmi_held_no_writes", 32'(obsQ.size()), 32'd0);

      runFrame(1'b1, 1'b1, 8'h10, 8'd1, 1'b0);
      runFrame(1'b1, 1'b1, 8'($urandom), 8'd197, 1'b0);
      runFrame(1'b1, 1'b0, 8'($urandom), 8'd3, 1'b0);
      runFrame(1'b0, 1'b1, 8'($urandom), 8'd50, 1'b0);
      runFrame(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b1);

      // Reset while the first WR_Y strobe is on the bus
      @(negedge clk);
      bus.nmi = 1'b0;
      applyStimulus(1'b1, 1'b1, 8'h33, 8'd7);
      @(negedge clk);
      bus.nmi = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         if (bus.ppu_cs === 1'b0 && bus.address === 3'd4) found = 1'b1;
      end
      checkOutput("reached_wr_y", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midframe_reset_bus", 32'({bus.ppu_cs, bus.ppu_rw, bus.address, bus.ppu_data}), 32'h1000);
      checkOutput("midframe_reset_flags", 32'({bus.busy, bus.frame_done, bus.tbl_idx}), 32'd0);
      mBase  = 0;
      mFineX = 0;
      @(negedge clk);
      rst_n = 1'b1;
      busyCycles = 0;
      repeat (5) @(negedge clk);
      checkOutput("post_reset_nmi_held", 32'(busyCycles), 32'd0);

      runFrame(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);

      for (int f = 0; f < 20; f++)
         runFrame(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);

      // Enough scrolled frames for fine_x to wrap past 0xFF
      for (int f = 0; f < 260; f++)
         runFrame(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ppu_oam_animator.md
PPU_OAM_ANIMATOR -- requirements
Module: ppu_oam_animator

Interface
REQ-001 Parameter NUM_SPR, default 4, number of animated sprites (1..16); sprite k uses OAM entry k.
REQ-002 Parameter TBL_DEPTH, default 200, trajectory table entries (2..256).
REQ-003 Parameter PHASE, default 25, table-index offset between consecutive sprites (0..TBL_DEPTH-1).
REQ-004 Parameter WAIT_CYC, default 1, idle cycles after every write strobe (1..7).
REQ-005 clk  in  1  CPU clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 nmi  in  1  PPU NMI output; the rising edge starts a frame update.
REQ-008 enable  in  1  high permits frame updates; sampled on the nmi edge only.
REQ-009 scroll_en  in  1  high includes the two scroll writes in the frame sequence.
REQ-010 scroll_y  in  8  coarse/fine Y scroll value for the second $2005 write.
REQ-011 step  in  8  base-index advance per frame; taken modulo TBL_DEPTH.
REQ-012 tbl_idx  out  8  registered trajectory-table index; table has 1-cycle read latency.
REQ-013 tbl_x, tbl_y  in  8 each  table data for the tbl_idx of the previous cycle.
REQ-014 address  out  3  PPU register select.
REQ-015 ppu_data  out  8  PPU write data.
REQ-016 ppu_rw  out  1  high during a write strobe, low otherwise.
REQ-017 ppu_cs  out  1  active-low chip select; low for exactly one cycle per write.
REQ-018 busy  out  1  high from the accepted nmi edge until DONE is exited.
REQ-019 frame_done  out  1  one-cycle pulse when the frame sequence completes.
REQ-020 overrun  out  1  one-cycle pulse when an nmi rising edge arrives while busy.

Function
REQ-021 The nmi edge SHALL be detected as nmi=1 with a registered prev_nmi=0; enable=0 at the edge SHALL cause no writes and no change to the base index.
REQ-022 FSM states SHALL be IDLE, SCR_X, SCR_Y, OAM_Y_ADDR, FETCH, WR_Y, OAM_X_ADDR, WR_X, WAIT and DONE; WAIT holds for WAIT_CYC cycles and then moves to the successor of the preceding write.
REQ-023 The sequence SHALL be: SCR_X, then SCR_Y (both only if scroll_en was 1 at the edge); then for k=0..NUM_SPR-1: FETCH, OAM_Y_ADDR, WR_Y, OAM_X_ADDR, WR_X; then DONE, then IDLE.
REQ-024 SCR_X SHALL write address 5 with the fine_x counter, then increment fine_x by 1 modulo 256; SCR_Y SHALL write address 5 with scroll_y.
REQ-025 OAM_Y_ADDR SHALL write address 3 with data 4k; WR_Y SHALL write address 4 with tbl_y.
REQ-026 OAM_X_ADDR SHALL write address 3 with data 4k+3; WR_X SHALL write address 4 with tbl_x.
REQ-027 FETCH SHALL drive tbl_idx=(base+k*PHASE) mod TBL_DEPTH; tbl_x and tbl_y SHALL be captured at the end of the following cycle and held for that sprite.
REQ-028 Modulo arithmetic SHALL use a width of at least 9 bits to avoid overflow before reduction.
REQ-029 In DONE, base SHALL become (base+step) mod TBL_DEPTH, wrapping TBL_DEPTH-1 to 0 as appropriate; frame_done SHALL pulse.
REQ-030 Outside write strobes: ppu_cs=1, ppu_rw=0, address=0, ppu_data=0; no tri-state.
REQ-031 An nmi edge while busy SHALL be ignored (no restart) and SHALL pulse overrun.
REQ-032 scroll_en, scroll_y and step SHALL be latched at the accepted nmi edge and remain stable for the whole frame.
REQ-033 Sequence length with scroll_en=1 SHALL be (2+4*NUM_SPR)*(1+WAIT_CYC)+NUM_SPR+1 cycles from leaving IDLE to reaching IDLE.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, base=0, fine_x=0, prev_nmi=0, tbl_idx=0, busy=0, frame_done=0, overrun=0 and all bus outputs to their idle values, including mid-sequence.
REQ-035 After reset release, a nmi held high SHALL NOT trigger a frame until it falls and rises again.

Verification
REQ-036 Defaults, scroll_en=1, scroll_y=0x10, step=1, one nmi edge -> writes in order (5,0x00) (5,0x10) (3,0x00) (4,Y[0]) (3,0x03) (4,X[0]) (3,0x04) (4,Y[25]) ... (4,X[75]); frame_done pulses; base=1.
REQ-037 step=3, base=198, TBL_DEPTH=200 -> base becomes 1 after the frame; sprite 3 fetches index (198+75) mod 200=73.
REQ-038 A second nmi edge during a busy frame -> overrun pulses once and the write sequence is unchanged and not restarted.
REQ-039 enable=0 at the nmi edge -> no ppu_cs pulse, base unchanged; scroll_en=0 -> the first write is (3,0x00).
REQ-040 rst_n asserted mid-WR_Y -> outputs return to idle the same cycle; the next frame starts with fine_x=0 and base=0.
REQ-041 256 frames with scroll_en=1 -> fine_x data wraps from 0xFF to 0x00; each strobe has ppu_cs low for exactly one cycle, followed by WAIT_CYC idle cycles.
